// File: rtl/bcd_key_enc_pkg.sv
// bcd_key_enc_pkg: shared FSM state encoding and no-key code for the BCD key encoder
package bcd_key_enc_pkg;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  localparam logic [3:0] NONE = 4'hF;
endpackage

// File: rtl/bcd_prio_enc.sv
// bcd_prio_enc: active-low 10-key priority encoder, highest pressed index wins, NONE when idle
module bcd_prio_enc
  import bcd_key_enc_pkg::*;
(
  input  logic [9:0] key_l,
  output logic [3:0] code
);
  always_comb begin
    code = NONE;
    for (int i = 0; i < 10; i++) code = key_l[i] ? code : 4'(i);
  end
endmodule

// File: rtl/bcd_key_encoder.sv
// bcd_key_encoder: debounced 10-key to BCD encoder with valid/ready output and sticky overrun.
// Define BCD_KEY_ENC_REPEAT_EN to re-issue a held key every REPEAT_CYCLES cycles.
module bcd_key_encoder
  import bcd_key_enc_pkg::*;
#(
  parameter int DEB_CYCLES    = 16,
  parameter int REPEAT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_l,
  output logic [3:0] bcd,
  output logic       bcd_valid,
  input  logic       bcd_ready,
  output logic       key_down,
  output logic       overrun
);
  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);
  if (DEB_CYCLES < 2 || DEB_CYCLES > 65535 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("bcd_key_encoder: parameter out of range");
  end
  logic [9:0] sync1, sync2;
  logic [3:0] code, cand, cand_n;
  logic [15:0] cnt, cnt_n;
  state_t state, state_n;
  logic deb_accept, accept, slot_free;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_l;
      sync2 <= sync1;
    end
  bcd_prio_enc u_enc (.key_l(sync2), .code(code));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    deb_accept = 1'b0;
    unique case (state)
      IDLE: if (code != NONE) begin
        cand_n = code;
        cnt_n = '0;
        state_n = DEBOUNCE;
      end
      DEBOUNCE: if (code == NONE) state_n = IDLE;
        else if (code != cand) begin
          cand_n = code;
          cnt_n = '0;
        end else if (cnt == DEB_LAST) begin
          deb_accept = 1'b1;
          state_n = PRESSED;
        end else cnt_n = cnt + 16'd1;
      PRESSED: if (code != cand) begin
        cnt_n = '0;
        state_n = RELEASE;
      end
      RELEASE: if (code != NONE) begin
        cnt_n = '0;
        state_n = PRESSED;
      end else if (cnt == DEB_LAST) state_n = IDLE;
        else cnt_n = cnt + 16'd1;
    endcase
  end
  always_comb key_down = state == PRESSED || state == RELEASE;
`ifdef BCD_KEY_ENC_REPEAT_EN
  logic [31:0] rep_cnt;
  logic rep_hold, rep_fire;
  assign rep_hold = state == PRESSED && state_n == PRESSED;
  assign rep_fire = rep_hold && rep_cnt == 32'(REPEAT_CYCLES - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) rep_cnt <= '0;
    else rep_cnt <= rep_hold && !rep_fire ? rep_cnt + 32'd1 : '0;
  assign accept = deb_accept | rep_fire;
`else
  assign accept = deb_accept;
`endif
  // a transfer in the accept cycle frees the slot, so back-to-back digits are not lost
  assign slot_free = !bcd_valid || bcd_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      cand <= NONE;
      bcd <= '0;
      bcd_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cnt <= cnt_n;
      cand <= cand_n;
      bcd <= accept && slot_free ? cand : bcd;
      bcd_valid <= accept || (bcd_valid && !bcd_ready);
      overrun <= overrun || (accept && !slot_free);
    end
endmodule
